// File: rtl/keccak_rho_pi_unit_if.sv
// Handshake/bus bundle for keccak_rho_pi_unit: input state side, result side and the legacy done pulse.
interface keccak_rho_pi_unit_if #(
    parameter int LANE_W = 64
);
    localparam int STATE_W = 25 * LANE_W;

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic               inv;
    logic [STATE_W-1:0] state_in;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;
    logic               done;

    modport master (
        output in_valid, mode, inv, state_in, out_ready,
        input  in_ready, out_valid, state_out, done
    );

    modport slave (
        input  in_valid, mode, inv, state_in, out_ready,
        output in_ready, out_valid, state_out, done
    );
endinterface

// File: rtl/keccak_rho_pi_unit.sv
// Keccak rho+pi step (pass / pi / rho / rho-then-pi) with one result register and valid/ready on both sides.
// Optional inverse transforms are built only when KECCAK_RHOPI_INV_EN is defined.
module keccak_rho_pi_unit #(
    parameter int LANE_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    keccak_rho_pi_unit_if.slave  bus
);
    localparam int STATE_W = 25 * LANE_W;

    // Rotation offsets, indexed [x*5 + y].
    localparam int R_TAB [0:24] = '{
         0, 36,  3, 41, 18,
         1, 44, 10, 45,  2,
        62,  6, 43, 15, 61,
        28, 55, 25, 21, 56,
        27, 20, 39,  8, 14
    };

    if (!(LANE_W == 1 || LANE_W == 2 || LANE_W == 4 || LANE_W == 8 ||
          LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
        $error("keccak_rho_pi_unit: LANE_W must be a power of two from 1 to 64");
    end

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] a, input int r);
        return (a << r) | (a >> (LANE_W - r));
    endfunction

    function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] a, input int r);
        return (a >> r) | (a << (LANE_W - r));
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_done;
    logic [STATE_W-1:0] r_state_out;
    logic               w_in_ready;
    logic               w_accept;
    logic [STATE_W-1:0] w_result;
    logic [STATE_W-1:0] w_rho_fwd;
    logic [STATE_W-1:0] w_pi_fwd;
    logic [STATE_W-1:0] w_rhopi_fwd;
`ifdef KECCAK_RHOPI_INV_EN
    logic [STATE_W-1:0] w_pi_inv;
    logic [STATE_W-1:0] w_rho_inv;
    logic [STATE_W-1:0] w_rhopi_inv;
`else
    logic               w_unused_inv;
    assign w_unused_inv = bus.inv;
`endif

    // Pure lane wiring: lane LI=(x,y) moves to lane PO=(y,(2x+3y)%5) under pi.
    for (genvar gy = 0; gy < 5; gy++) begin : g_y
        for (genvar gx = 0; gx < 5; gx++) begin : g_x
            localparam int LI  = gx + 5 * gy;
            localparam int PO  = gy + 5 * ((2 * gx + 3 * gy) % 5);
            localparam int ROT = R_TAB[gx * 5 + gy] % LANE_W;

            assign w_rho_fwd[LI*LANE_W +: LANE_W]   = rotl(bus.state_in[LI*LANE_W +: LANE_W], ROT);
            assign w_pi_fwd[PO*LANE_W +: LANE_W]    = bus.state_in[LI*LANE_W +: LANE_W];
            assign w_rhopi_fwd[PO*LANE_W +: LANE_W] = w_rho_fwd[LI*LANE_W +: LANE_W];
`ifdef KECCAK_RHOPI_INV_EN
            assign w_pi_inv[LI*LANE_W +: LANE_W]    = bus.state_in[PO*LANE_W +: LANE_W];
            assign w_rho_inv[LI*LANE_W +: LANE_W]   = rotr(bus.state_in[LI*LANE_W +: LANE_W], ROT);
            assign w_rhopi_inv[LI*LANE_W +: LANE_W] = rotr(w_pi_inv[LI*LANE_W +: LANE_W], ROT);
`endif
        end
    end

    // Select the transform requested for the state being accepted.
    always_comb begin
        w_result = bus.state_in;
`ifdef KECCAK_RHOPI_INV_EN
        case ({bus.inv, bus.mode})
            3'b000:  w_result = bus.state_in;
            3'b001:  w_result = w_pi_fwd;
            3'b010:  w_result = w_rho_fwd;
            3'b011:  w_result = w_rhopi_fwd;
            3'b100:  w_result = bus.state_in;
            3'b101:  w_result = w_pi_inv;
            3'b110:  w_result = w_rho_inv;
            3'b111:  w_result = w_rhopi_inv;
            default: w_result = bus.state_in;
        endcase
`else
        case (bus.mode)
            2'b00:   w_result = bus.state_in;
            2'b01:   w_result = w_pi_fwd;
            2'b10:   w_result = w_rho_fwd;
            2'b11:   w_result = w_rhopi_fwd;
            default: w_result = bus.state_in;
        endcase
`endif
    end

    // Handshake and next-state logic; out_ready reaches in_ready combinationally so FULL can refill back-to-back.
    always_comb begin
        w_in_ready  = (r_state == ST_EMPTY) | bus.out_ready;
        w_accept    = bus.in_valid & w_in_ready;
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_FULL;
                else          w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                if (bus.out_ready & ~bus.in_valid) w_state_nxt = ST_EMPTY;
                else                               w_state_nxt = ST_FULL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register, result register and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_done      <= 1'b0;
            r_state_out <= {STATE_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_accept;
            if (w_accept) r_state_out <= w_result;
            else          r_state_out <= r_state_out;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.done      = r_done;
    assign bus.state_out = r_state_out;
endmodule
